// File: rtl/squeeze_stream_ctrl.sv
// Keccak squeeze controller: slices the rate part of the state into AXI-Stream beats
// and requests a permutation whenever a rate block has been fully emitted.
module squeeze_stream_ctrl #(
  parameter int DWIDTH         = 256,
  parameter int LEN_WIDTH      = 16,
  parameter int MODE_SEL_WIDTH = 3,
  parameter int RATE_WIDTH     = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [MODE_SEL_WIDTH-1:0] mode_i,
  input  logic [RATE_WIDTH-1:0]     rate_i,
  input  logic [LEN_WIDTH-1:0]      out_len_i,
  input  logic                      stop_i,
  input  logic [1599:0]             state_array_i,
  output logic                      perm_req_o,
  input  logic                      perm_ack_i,
  output logic [DWIDTH-1:0]         m_tdata_o,
  output logic [DWIDTH/8-1:0]       m_tkeep_o,
  output logic                      m_tlast_o,
  output logic                      m_tvalid_o,
  input  logic                      m_tready_i,
  output logic                      busy_o,
  output logic                      done_o
);

  // Mode encoding shared with the Keccak core
  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHA3_224 = MODE_SEL_WIDTH'(0);
  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHA3_256 = MODE_SEL_WIDTH'(1);
  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHA3_384 = MODE_SEL_WIDTH'(2);
  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHA3_512 = MODE_SEL_WIDTH'(3);

  localparam int BEAT_BYTES = DWIDTH / 8;
  localparam int MAXW_A     = (LEN_WIDTH > RATE_WIDTH) ? LEN_WIDTH : RATE_WIDTH;
  localparam int MAXW       = (MAXW_A > $clog2(BEAT_BYTES + 1)) ? MAXW_A : $clog2(BEAT_BYTES + 1);
  localparam int CW         = MAXW + 1;

  typedef enum logic [1:0] {IDLE, STREAM, PERM} state_t;

  state_t                state_reg, state_next;
  logic [RATE_WIDTH-1:0] rate_bytes_reg, rate_bytes_next;
  logic [RATE_WIDTH-1:0] offset_reg, offset_next;
  logic [LEN_WIDTH-1:0]  len_reg, len_next;
  logic [LEN_WIDTH-1:0]  total_reg, total_next;
  logic                  stop_pend_reg, stop_pend_next;
  logic                  done_reg, done_next;

  logic                  bounded;
  logic                  tvalid;
  logic                  handshake;
  logic                  last_beat;
  logic                  rate_end;
  logic                  stop_now;
  logic [CW-1:0]         rem_rate;
  logic [CW-1:0]         rem_len;
  logic [CW-1:0]         keep_cnt;
  logic [CW-1:0]         off_sum;
  logic [CW-1:0]         tot_sum;
  logic [LEN_WIDTH-1:0]  len_sel;
  logic [DWIDTH-1:0]     window;
  logic [BEAT_BYTES-1:0] keep_bits;

  // A zero length latched from SHAKE means an unbounded stream
  assign bounded   = |len_reg;
  assign tvalid    = (state_reg == STREAM);
  assign handshake = tvalid && m_tready_i;
  assign stop_now  = stop_i || stop_pend_reg;
  assign rem_rate  = CW'(rate_bytes_reg) - CW'(offset_reg);
  assign rem_len   = CW'(len_reg) - CW'(total_reg);

  always_comb begin
    keep_cnt = CW'(BEAT_BYTES);
    if (rem_rate < keep_cnt) keep_cnt = rem_rate;
    if (bounded && (rem_len < keep_cnt)) keep_cnt = rem_len;
  end

  assign off_sum   = CW'(offset_reg) + keep_cnt;
  assign tot_sum   = CW'(total_reg) + keep_cnt;
  assign last_beat = bounded && (tot_sum == CW'(len_reg));
  assign rate_end  = (off_sum == CW'(rate_bytes_reg));

  always_comb begin
    len_sel = out_len_i;
    case (mode_i)
      MODE_SHA3_224: len_sel = LEN_WIDTH'(28);
      MODE_SHA3_256: len_sel = LEN_WIDTH'(32);
      MODE_SHA3_384: len_sel = LEN_WIDTH'(48);
      MODE_SHA3_512: len_sel = LEN_WIDTH'(64);
      default:       len_sel = out_len_i;
    endcase
  end

  assign window = DWIDTH'(state_array_i >> {offset_reg, 3'b000});

  generate
    for (genvar gi = 0; gi < BEAT_BYTES; gi++) begin : g_byte
      assign keep_bits[gi]          = tvalid && (CW'(gi) < keep_cnt);
      assign m_tdata_o[gi*8 +: 8]   = keep_bits[gi] ? window[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  assign m_tkeep_o  = keep_bits;
  assign m_tlast_o  = tvalid && last_beat;
  assign m_tvalid_o = tvalid;
  assign perm_req_o = (state_reg == PERM);
  assign busy_o     = (state_reg != IDLE);
  assign done_o     = done_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      rate_bytes_reg <= '0;
      offset_reg     <= '0;
      len_reg        <= '0;
      total_reg      <= '0;
      stop_pend_reg  <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rate_bytes_reg <= rate_bytes_next;
      offset_reg     <= offset_next;
      len_reg        <= len_next;
      total_reg      <= total_next;
      stop_pend_reg  <= stop_pend_next;
      done_reg       <= done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    rate_bytes_next = rate_bytes_reg;
    offset_next     = offset_reg;
    len_next        = len_reg;
    total_next      = total_reg;
    stop_pend_next  = stop_pend_reg;
    done_next       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          rate_bytes_next = rate_i >> 3;
          len_next        = len_sel;
          offset_next     = '0;
          total_next      = '0;
          stop_pend_next  = 1'b0;
          state_next      = STREAM;
        end
      end
      STREAM: begin
        if (handshake) begin
          offset_next = off_sum[RATE_WIDTH-1:0];
          // Unbounded streams pin the byte count at all-ones instead of wrapping
          if (!bounded && (tot_sum > CW'({LEN_WIDTH{1'b1}})))
            total_next = '1;
          else
            total_next = tot_sum[LEN_WIDTH-1:0];
          if (last_beat || stop_now) begin
            state_next     = IDLE;
            done_next      = 1'b1;
            stop_pend_next = 1'b0;
          end else if (rate_end) begin
            state_next = PERM;
          end
        end else if (stop_i) begin
          stop_pend_next = 1'b1;
        end
      end
      PERM: begin
        if (perm_ack_i) begin
          offset_next = '0;
          if (stop_now) begin
            state_next     = IDLE;
            done_next      = 1'b1;
            stop_pend_next = 1'b0;
          end else begin
            state_next = STREAM;
          end
        end else if (stop_i) begin
          stop_pend_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_squeeze_stream_ctrl.sv
// Directed bench for squeeze_stream_ctrl: a 256-bit instance for most scenarios
// and a 64-bit instance for the narrow SHA3-224 case.
module tb_squeeze_stream_ctrl;

  localparam logic [2:0] SHA3_224 = 3'd0;
  localparam logic [2:0] SHA3_256 = 3'd1;
  localparam logic [2:0] SHA3_512 = 3'd3;
  localparam logic [2:0] SHAKE128 = 3'd4;
  localparam logic [2:0] SHAKE256 = 3'd5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, start64;
  logic [2:0]    mode;
  logic [10:0]   rate;
  logic [15:0]   out_len;
  logic          stop;
  logic [1599:0] state_arr;
  logic          perm_ack;
  logic          tready;

  logic          perm_req, tlast, tvalid, busy, done;
  logic [255:0]  tdata;
  logic [31:0]   tkeep;
  logic          perm_req64, tlast64, tvalid64, busy64, done64;
  logic [63:0]   tdata64;
  logic [7:0]    tkeep64;

  int n_checks = 0;
  int n_pass   = 0;
  int perm_cnt = 0;
  int last_cnt = 0;
  int p0, l0;

  always #5 clk = ~clk;

  squeeze_stream_ctrl #(.DWIDTH(256), .LEN_WIDTH(16), .MODE_SEL_WIDTH(3), .RATE_WIDTH(11)) dut (
    .clk(clk), .rst(rst), .start_i(start), .mode_i(mode), .rate_i(rate), .out_len_i(out_len),
    .stop_i(stop), .state_array_i(state_arr), .perm_req_o(perm_req), .perm_ack_i(perm_ack),
    .m_tdata_o(tdata), .m_tkeep_o(tkeep), .m_tlast_o(tlast), .m_tvalid_o(tvalid),
    .m_tready_i(tready), .busy_o(busy), .done_o(done)
  );

  squeeze_stream_ctrl #(.DWIDTH(64), .LEN_WIDTH(16), .MODE_SEL_WIDTH(3), .RATE_WIDTH(11)) dut64 (
    .clk(clk), .rst(rst), .start_i(start64), .mode_i(mode), .rate_i(rate), .out_len_i(out_len),
    .stop_i(stop), .state_array_i(state_arr), .perm_req_o(perm_req64), .perm_ack_i(perm_ack),
    .m_tdata_o(tdata64), .m_tkeep_o(tkeep64), .m_tlast_o(tlast64), .m_tvalid_o(tvalid64),
    .m_tready_i(tready), .busy_o(busy64), .done_o(done64)
  );

  always @(posedge clk) begin
    if (perm_req) perm_cnt <= perm_cnt + 1;
    if (tvalid && tready && tlast) last_cnt <= last_cnt + 1;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [1599:0] make_state(input int base);
    logic [1599:0] s;
    s = '0;
    for (int n = 0; n < 200; n++) s[8*n +: 8] = 8'(base + n);
    return s;
  endfunction

  function automatic logic [255:0] pat(input int first, input int nbytes);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < nbytes; i++) r[8*i +: 8] = 8'(first + i);
    return r;
  endfunction

  task automatic do_start(input bit narrow, input logic [2:0] m, input logic [10:0] r, input logic [15:0] len);
    mode = m; rate = r; out_len = len;
    if (narrow) start64 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start64 = 1'b0;
  endtask

  // Waits for a valid beat, checks it, then lets the handshake happen (tready assumed 1)
  task automatic get_beat(input string tag, input bit narrow, input logic [255:0] ed,
                          input logic [31:0] ek, input bit el);
    int cyc;
    cyc = 0;
    while (!(narrow ? tvalid64 : tvalid) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".tvalid"}, 256'(narrow ? tvalid64 : tvalid), 256'(1));
    check({tag, ".tdata"}, narrow ? {192'b0, tdata64} : tdata, ed);
    check({tag, ".tkeep"}, narrow ? 256'(tkeep64) : 256'(tkeep), 256'(ek));
    check({tag, ".tlast"}, 256'(narrow ? tlast64 : tlast), 256'(el));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; start64 = 1'b0; mode = '0; rate = '0; out_len = '0;
    stop = 1'b0; perm_ack = 1'b0; tready = 1'b1; state_arr = make_state(0);
    repeat (2) @(negedge clk);
    check("reset.tvalid", 256'(tvalid), 256'(0));
    check("reset.perm_req", 256'(perm_req), 256'(0));
    check("reset.busy", 256'(busy), 256'(0));
    check("reset.done", 256'(done), 256'(0));
    check("reset.tdata", tdata, 256'(0));
    check("reset.tkeep", 256'(tkeep), 256'(0));
    check("reset.tlast", 256'(tlast), 256'(0));
    check("reset.tvalid64", 256'(tvalid64), 256'(0));
    rst = 1'b1;
    @(negedge clk);

    // SHA3-256: single full beat
    p0 = perm_cnt; l0 = last_cnt;
    do_start(0, SHA3_256, 11'd1088, 16'd0);
    get_beat("t1.b1", 0, pat(0, 32), 32'hFFFF_FFFF, 1'b1);
    check("t1.done", 256'(done), 256'(1));
    check("t1.busy", 256'(busy), 256'(0));
    @(negedge clk);
    check("t1.done_pulse", 256'(done), 256'(0));
    check("t1.no_perm", 256'(perm_cnt - p0), 256'(0));
    check("t1.one_last", 256'(last_cnt - l0), 256'(1));

    // SHA3-512 with backpressure on beat 1
    do_start(0, SHA3_512, 11'd576, 16'd0);
    tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t2.hold%0d.tvalid", i), 256'(tvalid), 256'(1));
      check($sformatf("t2.hold%0d.tdata", i), tdata, pat(0, 32));
      check($sformatf("t2.hold%0d.tlast", i), 256'(tlast), 256'(0));
    end
    tready = 1'b1;
    get_beat("t2.b1", 0, pat(0, 32), 32'hFFFF_FFFF, 1'b0);
    get_beat("t2.b2", 0, pat(32, 32), 32'hFFFF_FFFF, 1'b1);
    check("t2.done", 256'(done), 256'(1));

    // SHAKE128, 200 bytes across one permutation
    do_start(0, SHAKE128, 11'd1344, 16'd200);
    for (int b = 0; b < 5; b++)
      get_beat($sformatf("t3.b%0d", b + 1), 0, pat(32 * b, 32), 32'hFFFF_FFFF, 1'b0);
    get_beat("t3.b6", 0, pat(160, 8), 32'h0000_00FF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3.wait%0d.perm_req", i), 256'(perm_req), 256'(1));
      check($sformatf("t3.wait%0d.tvalid", i), 256'(tvalid), 256'(0));
      @(negedge clk);
    end
    perm_ack = 1'b1; state_arr = make_state(64);
    @(negedge clk);
    perm_ack = 1'b0;
    check("t3.ack.perm_req", 256'(perm_req), 256'(0));
    get_beat("t3.b7", 0, pat(64, 32), 32'hFFFF_FFFF, 1'b1);
    check("t3.done", 256'(done), 256'(1));
    state_arr = make_state(0);

    // SHAKE256 unbounded, ended by stop under backpressure
    l0 = last_cnt;
    do_start(0, SHAKE256, 11'd1088, 16'd0);
    for (int b = 0; b < 4; b++)
      get_beat($sformatf("t4.b%0d", b + 1), 0, pat(32 * b, 32), 32'hFFFF_FFFF, 1'b0);
    get_beat("t4.b5", 0, pat(128, 8), 32'h0000_00FF, 1'b0);
    check("t4.perm_req", 256'(perm_req), 256'(1));
    perm_ack = 1'b1; state_arr = make_state(64);
    @(negedge clk);
    perm_ack = 1'b0;
    tready = 1'b0; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t4.held.tvalid", 256'(tvalid), 256'(1));
    check("t4.held.busy", 256'(busy), 256'(1));
    check("t4.held.tdata", tdata, pat(64, 32));
    tready = 1'b1;
    get_beat("t4.b6", 0, pat(64, 32), 32'hFFFF_FFFF, 1'b0);
    check("t4.done", 256'(done), 256'(1));
    check("t4.busy", 256'(busy), 256'(0));
    check("t4.no_last", 256'(last_cnt - l0), 256'(0));
    state_arr = make_state(0);

    // 64-bit instance, SHA3-224
    do_start(1, SHA3_224, 11'd1152, 16'd0);
    get_beat("t5.b1", 1, pat(0, 8), 32'hFF, 1'b0);
    get_beat("t5.b2", 1, pat(8, 8), 32'hFF, 1'b0);
    get_beat("t5.b3", 1, pat(16, 8), 32'hFF, 1'b0);
    get_beat("t5.b4", 1, pat(24, 4), 32'h0F, 1'b1);
    check("t5.done", 256'(done64), 256'(1));

    // Reset while requesting a permutation
    do_start(0, SHAKE256, 11'd1088, 16'd0);
    for (int i = 0; i < 50 && !perm_req; i++) @(negedge clk);
    check("t6.reach_perm", 256'(perm_req), 256'(1));
    #2 rst = 1'b0;
    #1;
    check("t6.perm.perm_req", 256'(perm_req), 256'(0));
    check("t6.perm.tvalid", 256'(tvalid), 256'(0));
    check("t6.perm.busy", 256'(busy), 256'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset in the middle of a stalled beat
    do_start(0, SHA3_512, 11'd576, 16'd0);
    tready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("t6.beat.tvalid", 256'(tvalid), 256'(0));
    check("t6.beat.tdata", tdata, 256'(0));
    check("t6.beat.tkeep", 256'(tkeep), 256'(0));
    check("t6.beat.tlast", 256'(tlast), 256'(0));
    check("t6.beat.busy", 256'(busy), 256'(0));
    @(negedge clk);
    rst = 1'b1; tready = 1'b1;
    @(negedge clk);
    do_start(0, SHA3_256, 11'd1088, 16'd0);
    get_beat("t6.restart", 0, pat(0, 32), 32'hFFFF_FFFF, 1'b1);
    check("t6.done", 256'(done), 256'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
